nfc_wb_slave: RTL and testbench

//  Wishbone slave front-end of the NAND flash controller (NFC).
//  - Maps a one-page byte buffer and four control/status registers (ROW_ADDR, NFC_CMD, NFC_READY, NFC_ERROR) onto the bus.
//  - Starts flash operations in the NFC core and reports READY plus latched error flags back to the host.

---
 rtl/nfc_pkg.sv | 41 ++++
 rtl/nfc_wb_slave_if.sv | 24 ++
 rtl/nfc_page_buffer.sv | 27 ++
 rtl/nfc_wb_slave.sv | 146 ++++++++++++++
 tb/tb_nfc_wb_slave.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/nfc_pkg.sv
// NFC wishbone front-end shared definitions.
// Widths, register map, command codes and error bit positions.
package nfc_pkg;

  localparam int WB_ADDR_WIDTH  = 16;
  localparam int WB_DATA_WIDTH  = 32;
  localparam int BUF_ADDR_WIDTH = 12;
  localparam int BUF_DATA_WIDTH = 8;
  localparam int ROW_ADDR_WIDTH = 17;
  localparam int BUF_DEPTH      = 1 << BUF_ADDR_WIDTH;

  localparam logic [WB_ADDR_WIDTH-1:0] REG_ROW_ADDR = 16'h1000;
  localparam logic [WB_ADDR_WIDTH-1:0] REG_CMD      = 16'h1001;
  localparam logic [WB_ADDR_WIDTH-1:0] REG_READY    = 16'h1002;
  localparam logic [WB_ADDR_WIDTH-1:0] REG_ERROR    = 16'h1003;

  localparam int ERR_ECC   = 0;
  localparam int ERR_ERASE = 1;
  localparam int ERR_PROG  = 2;

  typedef enum logic [2:0] {
    CMD_NONE         = 3'd0,
    CMD_READ_PAGE    = 3'd1,
    CMD_PROGRAM_PAGE = 3'd2,
    CMD_BLOCK_ERASE  = 3'd3,
    CMD_RESET        = 3'd4,
    CMD_READ_ID      = 3'd5
  } nfc_cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } nfc_state_e;

  function automatic logic cmd_valid(input logic [2:0] c);
    return c inside {CMD_READ_PAGE, CMD_PROGRAM_PAGE,
                     CMD_BLOCK_ERASE, CMD_RESET,
                     CMD_READ_ID};
  endfunction

endpackage

// File: rtl/nfc_wb_slave_if.sv
// Wishbone classic bus bundle between host master and NFC slave.
// Signal names follow the controller's bus port naming.
interface nfc_wb_slave_if;
  import nfc_pkg::*;

  logic [WB_ADDR_WIDTH-1:0] wb_addr;
  logic [WB_DATA_WIDTH-1:0] wb_data_i_s;
  logic                     wb_we;
  logic                     wb_stb;
  logic                     wb_cyc;
  logic                     wb_ack;
  logic [WB_DATA_WIDTH-1:0] wb_data_o_s;

  modport slave (
    input  wb_addr, wb_data_i_s, wb_we, wb_stb, wb_cyc,
    output wb_ack, wb_data_o_s
  );

  modport master (
    output wb_addr, wb_data_i_s, wb_we, wb_stb, wb_cyc,
    input  wb_ack, wb_data_o_s
  );

endinterface

// File: rtl/nfc_page_buffer.sv
// One-page byte RAM, true dual port, synchronous read.
// Port A serves the host, port B the flash core.
module nfc_page_buffer
  import nfc_pkg::*;
(
  input  logic                      clk_i,
  input  logic [BUF_ADDR_WIDTH-1:0] a_addr,
  input  logic                      a_we,
  input  logic [BUF_DATA_WIDTH-1:0] a_wdata,
  output logic [BUF_DATA_WIDTH-1:0] a_rdata,
  input  logic [BUF_ADDR_WIDTH-1:0] b_addr,
  input  logic                      b_we,
  input  logic [BUF_DATA_WIDTH-1:0] b_wdata,
  output logic [BUF_DATA_WIDTH-1:0] b_rdata
);

  logic [BUF_DATA_WIDTH-1:0] mem [BUF_DEPTH];

  // Core write is issued last so it wins an address collision.
  always_ff @(posedge clk_i) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/nfc_wb_slave.sv
// Wishbone slave front-end of the NAND flash controller.
// Bus decode, single-cycle ack, control registers, IDLE/BUSY FSM.
module nfc_wb_slave
  import nfc_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  nfc_wb_slave_if.slave             wb,
  output logic                      nfc_start,
  output logic [2:0]                nfc_cmd,
  output logic [ROW_ADDR_WIDTH-1:0] nfc_row_addr,
  input  logic                      nfc_done,
  input  logic [2:0]                nfc_errors,
  input  logic [BUF_ADDR_WIDTH-1:0] core_buf_addr,
  input  logic                      core_buf_we,
  input  logic [BUF_DATA_WIDTH-1:0] core_buf_wdata,
  output logic [BUF_DATA_WIDTH-1:0] core_buf_rdata
);

  nfc_state_e state_q, state_d;

  logic                      ack_q;
  logic                      sel_buf_q;
  logic [WB_DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [ROW_ADDR_WIDTH-1:0] row_addr_q;
  logic [ROW_ADDR_WIDTH-1:0] row_q;
  logic [2:0]                err_q;
  logic [2:0]                cmd_q;
  logic                      start_q;
  logic [BUF_DATA_WIDTH-1:0] host_q;

  logic accept;
  logic is_buf;
  logic cmd_wr;
  logic row_wr;
  logic host_we;
  logic start_d;
  logic err_load;
  logic unused_wdata;

  assign accept  = wb.wb_stb & wb.wb_cyc & ~ack_q;
  assign is_buf  =
    ~|wb.wb_addr[WB_ADDR_WIDTH-1:BUF_ADDR_WIDTH];
  assign cmd_wr  = accept & wb.wb_we &
                   (wb.wb_addr == REG_CMD);
  assign row_wr  = accept & wb.wb_we &
                   (wb.wb_addr == REG_ROW_ADDR);
  assign host_we = accept & wb.wb_we & is_buf &
                   (state_q == ST_IDLE);

  assign unused_wdata =
    ^wb.wb_data_i_s[WB_DATA_WIDTH-1:ROW_ADDR_WIDTH];

  nfc_page_buffer u_buf (
    .clk_i   (clk_i),
    .a_addr  (wb.wb_addr[BUF_ADDR_WIDTH-1:0]),
    .a_we    (host_we),
    .a_wdata (wb.wb_data_i_s[BUF_DATA_WIDTH-1:0]),
    .a_rdata (host_q),
    .b_addr  (core_buf_addr),
    .b_we    (core_buf_we),
    .b_wdata (core_buf_wdata),
    .b_rdata (core_buf_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Done takes precedence: CMD writes are only looked at in IDLE.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    err_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_wr && cmd_valid(wb.wb_data_i_s[2:0])) begin
          start_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (nfc_done) begin
          err_load = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      (wb.wb_addr == REG_ROW_ADDR):
        rdata_d = WB_DATA_WIDTH'(row_addr_q);
      (wb.wb_addr == REG_READY):
        rdata_d = WB_DATA_WIDTH'(state_q == ST_IDLE);
      (wb.wb_addr == REG_ERROR):
        rdata_d = WB_DATA_WIDTH'(err_q);
      default:
        rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q      <= 1'b0;
      sel_buf_q  <= 1'b0;
      rdata_q    <= '0;
      row_addr_q <= '0;
      row_q      <= '0;
      err_q      <= '0;
      cmd_q      <= '0;
      start_q    <= 1'b0;
    end else begin
      ack_q   <= accept;
      start_q <= start_d;
      if (accept) begin
        sel_buf_q <= is_buf;
        rdata_q   <= rdata_d;
      end
      if (row_wr)
        row_addr_q <= wb.wb_data_i_s[ROW_ADDR_WIDTH-1:0];
      if (start_d) begin
        cmd_q <= wb.wb_data_i_s[2:0];
        row_q <= row_addr_q;
        err_q <= '0;
      end else if (err_load) begin
        err_q <= nfc_errors;
      end
    end
  end

  // Buffer bytes come straight from the RAM's registered output.
  assign wb.wb_ack      = ack_q;
  assign wb.wb_data_o_s = !ack_q    ? '0 :
                          sel_buf_q ? WB_DATA_WIDTH'(host_q) :
                                      rdata_q;

  assign nfc_start    = start_q;
  assign nfc_cmd      = cmd_q;
  assign nfc_row_addr = row_q;

endmodule

// File: tb/tb_nfc_wb_slave.sv
// Directed bench for the NFC wishbone slave.
// Host accesses, core handshakes and buffer traffic.
module tb_nfc_wb_slave;
  import nfc_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        nfc_start;
  logic [2:0]  nfc_cmd;
  logic [16:0] nfc_row_addr;
  logic        nfc_done;
  logic [2:0]  nfc_errors;
  logic [11:0] core_buf_addr;
  logic        core_buf_we;
  logic [7:0]  core_buf_wdata;
  logic [7:0]  core_buf_rdata;

  nfc_wb_slave_if bus ();

  nfc_wb_slave dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wb             (bus),
    .nfc_start      (nfc_start),
    .nfc_cmd        (nfc_cmd),
    .nfc_row_addr   (nfc_row_addr),
    .nfc_done       (nfc_done),
    .nfc_errors     (nfc_errors),
    .core_buf_addr  (core_buf_addr),
    .core_buf_we    (core_buf_we),
    .core_buf_wdata (core_buf_wdata),
    .core_buf_rdata (core_buf_rdata)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;

  logic        start_seen;
  logic        start_after;
  logic [2:0]  cmd_seen;
  logic [16:0] row_seen;
  logic [31:0] q;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h",
                tag, got, exp);
  endtask

  // Entered and left at posedge+1 with ack low.
  task automatic access(input logic [15:0] a,
                        input logic we,
                        input logic [31:0] d,
                        input bit with_done,
                        input logic [2:0] errs,
                        output logic [31:0] rd);
    bus.wb_addr     = a;
    bus.wb_we       = we;
    bus.wb_data_i_s = d;
    bus.wb_stb      = 1'b1;
    bus.wb_cyc      = 1'b1;
    if (with_done) begin
      nfc_done   = 1'b1;
      nfc_errors = errs;
    end
    @(posedge clk_i); #1;
    nfc_done = 1'b0;
    chk("ack_rise", 32'(bus.wb_ack), 32'd1);
    rd          = bus.wb_data_o_s;
    start_seen  = nfc_start;
    cmd_seen    = nfc_cmd;
    row_seen    = nfc_row_addr;
    bus.wb_stb  = 1'b0;
    bus.wb_cyc  = 1'b0;
    bus.wb_we   = 1'b0;
    @(posedge clk_i); #1;
    chk("ack_fall", 32'(bus.wb_ack), 32'd0);
    start_after = nfc_start;
  endtask

  task automatic wr(input logic [15:0] a,
                    input logic [31:0] d);
    logic [31:0] dummy;
    access(a, 1'b1, d, 1'b0, 3'd0, dummy);
  endtask

  task automatic rd(input string tag,
                    input logic [15:0] a,
                    input logic [31:0] exp);
    logic [31:0] v;
    access(a, 1'b0, 32'd0, 1'b0, 3'd0, v);
    chk(tag, v, exp);
  endtask

  task automatic done_pulse(input logic [2:0] e);
    nfc_done   = 1'b1;
    nfc_errors = e;
    @(posedge clk_i); #1;
    nfc_done   = 1'b0;
  endtask

  task automatic core_wr(input logic [11:0] a,
                         input logic [7:0] d);
    core_buf_addr  = a;
    core_buf_we    = 1'b1;
    core_buf_wdata = d;
    @(posedge clk_i); #1;
    core_buf_we    = 1'b0;
  endtask

  initial begin
    rst_i           = 1'b1;
    bus.wb_addr     = '0;
    bus.wb_data_i_s = '0;
    bus.wb_we       = 1'b0;
    bus.wb_stb      = 1'b0;
    bus.wb_cyc      = 1'b0;
    nfc_done        = 1'b0;
    nfc_errors      = '0;
    core_buf_addr   = '0;
    core_buf_we     = 1'b0;
    core_buf_wdata  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ack", 32'(bus.wb_ack), 32'd0);
    chk("rst_dout", bus.wb_data_o_s, 32'd0);
    chk("rst_start", 32'(nfc_start), 32'd0);
    chk("rst_cmd", 32'(nfc_cmd), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    rd("ready_rst", 16'h1002, 32'h1);
    rd("error_rst", 16'h1003, 32'h0);
    rd("row_rst", 16'h1000, 32'h0);

    // stb held across ack: ack must drop, then re-accept.
    bus.wb_addr = 16'h1002;
    bus.wb_stb  = 1'b1;
    bus.wb_cyc  = 1'b1;
    @(posedge clk_i); #1;
    chk("held_ack1", 32'(bus.wb_ack), 32'd1);
    chk("held_data", bus.wb_data_o_s, 32'h1);
    @(posedge clk_i); #1;
    chk("held_gap", 32'(bus.wb_ack), 32'd0);
    @(posedge clk_i); #1;
    chk("held_ack2", 32'(bus.wb_ack), 32'd1);
    bus.wb_stb = 1'b0;
    bus.wb_cyc = 1'b0;
    @(posedge clk_i); #1;
    chk("held_end", 32'(bus.wb_ack), 32'd0);

    wr(16'h0010, 32'h0000_00A5);
    rd("buf_10", 16'h0010, 32'h0000_00A5);
    wr(16'h0011, 32'hFFFF_FF5A);
    rd("buf_11_low", 16'h0011, 32'h0000_005A);
    wr(16'h0005, 32'h33);
    rd("buf_05", 16'h0005, 32'h33);
    access(16'h0FFF, 1'b0, 32'd0, 1'b0, 3'd0, q);
    wr(16'h2000, 32'h1234);
    rd("unmapped", 16'h2000, 32'h0);
    rd("cmd_reads0", 16'h1001, 32'h0);

    wr(16'h1000, 32'h0001_ABCD);
    rd("row_rb", 16'h1000, 32'h0001_ABCD);
    wr(16'h1001, 32'd2);
    chk("prog_start", 32'(start_seen), 32'd1);
    chk("prog_cmd", 32'(cmd_seen), 32'd2);
    chk("prog_row", 32'(row_seen), 32'h1ABCD);
    chk("start_1cyc", 32'(start_after), 32'd0);
    rd("ready_busy", 16'h1002, 32'h0);
    wr(16'h1000, 32'h42);
    done_pulse(3'b100);
    rd("ready_done", 16'h1002, 32'h1);
    rd("error_prog", 16'h1003, 32'h4);

    wr(16'h1001, 32'd1);
    chk("rd_start", 32'(start_seen), 32'd1);
    chk("rd_row_new", 32'(row_seen), 32'h42);
    rd("error_clr", 16'h1003, 32'h0);
    wr(16'h1001, 32'd3);
    chk("busy_nostart", 32'(start_seen), 32'd0);
    wr(16'h0005, 32'h11);
    rd("busy_buf_drop", 16'h0005, 32'h33);

    // done and CMD write accepted on the same edge
    access(16'h1001, 1'b1, 32'd4, 1'b1, 3'b011, q);
    chk("coll_nostart", 32'(start_seen), 32'd0);
    rd("coll_ready", 16'h1002, 32'h1);
    rd("coll_error", 16'h1003, 32'h3);

    wr(16'h1001, 32'd5);
    chk("id_start", 32'(start_seen), 32'd1);
    chk("id_cmd", 32'(cmd_seen), 32'd5);
    core_wr(12'd1, 8'hEC);
    core_wr(12'd2, 8'hDA);
    core_wr(12'd3, 8'h10);
    core_wr(12'd4, 8'h95);
    done_pulse(3'b000);
    rd("id0", 16'h0001, 32'hEC);
    rd("id1", 16'h0002, 32'hDA);
    rd("id2", 16'h0003, 32'h10);
    rd("id3", 16'h0004, 32'h95);
    core_buf_addr = 12'h010;
    @(posedge clk_i); #1;
    chk("core_rd", 32'(core_buf_rdata), 32'hA5);

    wr(16'h1001, 32'd7);
    chk("bad7_nostart", 32'(start_seen), 32'd0);
    wr(16'h1001, 32'd0);
    chk("bad0_nostart", 32'(start_seen), 32'd0);
    rd("bad_ready", 16'h1002, 32'h1);
    wr(16'h1001, 32'd3);
    chk("erase_start", 32'(start_seen), 32'd1);
    done_pulse(3'b010);
    rd("error_erase", 16'h1003, 32'h2);

    wr(16'h1001, 32'd4);
    rd("busy_again", 16'h1002, 32'h0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    rd("rst_ready", 16'h1002, 32'h1);
    rd("rst_row", 16'h1000, 32'h0);
    done_pulse(3'b111);
    rd("late_done_rdy", 16'h1002, 32'h1);
    rd("late_done_err", 16'h1003, 32'h0);
    rd("buf_kept", 16'h0010, 32'hA5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
